// File: rtl/ccd_line_packer.sv
// ccd_line_packer
// Packs linear-CCD pixel strobes from the ADC driver into an AXI-Stream of
// DATA_WIDTH-bit pixels. Each line starts with DUMMY_LEAD discarded strobes;
// the next ACTIVE_PIX strobes are forwarded (MSBs kept) through a small
// first-word-fall-through FIFO. tlast marks the last pixel of a line and
// tuser marks the first pixel of every `rows`-line frame.
//
// Ports
//   clk, reset          pixel clock; asynchronous active-high reset
//   line_start          1-cycle pulse at start of a CCD line
//   pix_valid/pix_data  sample strobe and ADC sample
//   rows                lines per frame (0 behaves as 1)
//   m_axis_*            AXI-Stream master (tdata/tlast/tuser/tvalid, tready in)
//   overflow            sticky: an active pixel was dropped on a full FIFO
//   short_line          sticky: a line restarted before all active pixels arrived
module ccd_line_packer #(
    parameter int D_WIDTH    = 12,
    parameter int DATA_WIDTH = 8,
    parameter int DUMMY_LEAD = 32,
    parameter int ACTIVE_PIX = 2048,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic                  pix_valid,
    input  logic [D_WIDTH-1:0]    pix_data,
    input  logic [15:0]           rows,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow,
    output logic                  short_line
);

    localparam int DCW = $clog2(DUMMY_LEAD + 1);
    localparam int PCW = $clog2(ACTIVE_PIX + 1);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int WW  = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_ACTIVE,
        S_TRAIL
    } state_t;

    state_t                         state_q, state_d;
    logic [DCW-1:0]                 dummy_cnt_q, dummy_cnt_d;
    logic [PCW-1:0]                 pix_cnt_q, pix_cnt_d;
    logic [15:0]                    row_cnt_q, row_cnt_d;
    logic [15:0]                    rows_lat_q, rows_lat_d;
    logic                           short_line_q, short_line_d;
    logic                           overflow_q, overflow_d;
    logic [FIFO_DEPTH-1:0][WW-1:0]  mem_q, mem_d;
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  count_q, count_d;

    logic          push;
    logic [WW-1:0] push_word;
    logic          pix_last;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [WW-1:0] rd_word;

    // Only the sample MSBs are forwarded.
    logic unused_pix;
    assign unused_pix = ^pix_data;

    // Line sequencer: line_start always wins over a same-cycle strobe.
    always_comb begin
        state_d      = state_q;
        dummy_cnt_d  = dummy_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        row_cnt_d    = row_cnt_q;
        rows_lat_d   = rows_lat_q;
        short_line_d = short_line_q;
        push         = 1'b0;
        push_word    = '0;
        pix_last     = (pix_cnt_q == PCW'(ACTIVE_PIX - 1));

        if (line_start) begin
            state_d     = S_LEAD;
            dummy_cnt_d = '0;
            if (state_q == S_ACTIVE) begin
                // Aborted line: resync so the next line opens a new frame.
                short_line_d = 1'b1;
                row_cnt_d    = '0;
            end
        end else if (pix_valid) begin
            unique case (state_q)
                S_LEAD: begin
                    if (dummy_cnt_q == DCW'(DUMMY_LEAD - 1)) begin
                        state_d   = S_ACTIVE;
                        pix_cnt_d = '0;
                        if (row_cnt_q == '0) begin
                            rows_lat_d = (rows == '0) ? 16'd1 : rows;
                        end
                    end else begin
                        dummy_cnt_d = dummy_cnt_q + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    push      = 1'b1;
                    push_word = {(pix_cnt_q == '0) && (row_cnt_q == '0),
                                 pix_last,
                                 pix_data[D_WIDTH-1 -: DATA_WIDTH]};
                    if (pix_last) begin
                        state_d   = S_TRAIL;
                        row_cnt_d = (row_cnt_q >= rows_lat_q - 16'd1) ? '0
                                                                     : row_cnt_q + 16'd1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output FIFO: full is judged on the pre-cycle count, a concurrent pop frees a slot.
    always_comb begin
        pop        = (count_q != '0) && m_axis_tready;
        full       = (count_q == CW'(FIFO_DEPTH));
        wr_en      = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dummy_cnt_q  <= '0;
            pix_cnt_q    <= '0;
            row_cnt_q    <= '0;
            rows_lat_q   <= 16'd1;
            short_line_q <= 1'b0;
            overflow_q   <= 1'b0;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            dummy_cnt_q  <= dummy_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            row_cnt_q    <= row_cnt_d;
            rows_lat_q   <= rows_lat_d;
            short_line_q <= short_line_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Word fields are forced to zero while empty so reset drives a clean bus.
    always_comb begin
        rd_word       = mem_q[rd_ptr_q];
        m_axis_tvalid = (count_q != '0);
        {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? rd_word : '0;
        overflow      = overflow_q;
        short_line    = short_line_q;
    end

endmodule

// File: tb/tb_ccd_line_packer.sv
module tb_ccd_line_packer;

    localparam int DL = 4;
    localparam int AP = 8;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic [15:0] rows;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overflow;
    logic        short_line;

    int errors = 0;
    int checks = 0;

    // Reference model: position of the strobe within the current line,
    // frame row index and an ideal bounded queue for the FIFO.
    int         m_pos;
    int         m_row;
    int         m_lat;
    logic [9:0] mq[$];
    logic [9:0] exp_out[$];
    logic [9:0] obs_out[$];

    ccd_line_packer #(
        .D_WIDTH   (12),
        .DATA_WIDTH(8),
        .DUMMY_LEAD(DL),
        .ACTIVE_PIX(AP),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .line_start   (line_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .rows         (rows),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .overflow     (overflow),
        .short_line   (short_line)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b0 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
            obs_out.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end

    function automatic void model_reset();
        m_pos = -1;
        m_row = 0;
        m_lat = 1;
        mq.delete();
        exp_out.delete();
        obs_out.delete();
    endfunction

    function automatic void model_edge(bit ls, bit pv, logic [11:0] d, bit rdy);
        bit         pop;
        bit         push;
        logic [9:0] w;
        int         k;
        pop  = (mq.size() != 0) && rdy;
        push = 0;
        w    = '0;
        if (ls) begin
            if (m_pos >= DL && m_pos < DL + AP) m_row = 0;
            m_pos = 0;
        end else if (pv && m_pos >= 0) begin
            if (m_pos < DL) begin
                m_pos++;
                if (m_pos == DL && m_row == 0) m_lat = (rows == 0) ? 1 : int'(rows);
            end else if (m_pos < DL + AP) begin
                k    = m_pos - DL;
                w    = {(k == 0 && m_row == 0), (k == AP - 1), d[11:4]};
                push = 1;
                if (k == AP - 1) m_row = (m_row + 1 >= m_lat) ? 0 : m_row + 1;
                m_pos++;
            end
        end
        if (pop) exp_out.push_back(mq.pop_front());
        if (push && mq.size() < FD) mq.push_back(w);
    endfunction

    task automatic step(input bit ls, input bit pv, input logic [11:0] d);
        line_start = ls;
        pix_valid  = pv;
        pix_data   = d;
        @(posedge clk);
        model_edge(ls, pv, d, m_axis_tready);
        #1;
        line_start = 1'b0;
        pix_valid  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; line_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        rows = 16'd3; m_axis_tready = 1'b1;
        #3;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b expected 0", m_axis_tuser); end
        checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (short_line !== 1'b0) begin errors++; $display("FAIL reset_short_line: got %b expected 0", short_line); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_line();
        m_axis_tready = 1'b1;
        step(1, 0, '0);
        for (int n = 0; n < 14; n++) begin
            step(0, 1, 12'(n << 4));
            checks++;
            if (m_axis_tvalid !== (n >= DL && n < DL + AP)) begin
                errors++; $display("FAIL single_tvalid[%0d]: got %b expected %b", n, m_axis_tvalid, (n >= DL && n < DL + AP));
            end
            if (n >= DL && n < DL + AP) begin
                checks++;
                if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {(n == DL), (n == DL + AP - 1), 8'(n)}) begin
                    errors++; $display("FAIL single_word[%0d]: got %h expected %h", n,
                        {m_axis_tuser, m_axis_tlast, m_axis_tdata}, {(n == DL), (n == DL + AP - 1), 8'(n)});
                end
            end
        end
        step(0, 0, '0);
        checks++;
        if (obs_out.size() != AP) begin errors++; $display("FAIL single_count: got %0d expected %0d", obs_out.size(), AP); end
    endtask

    task automatic test_back_to_back();
        int nuser;
        apply_reset();
        rows = 16'd3; m_axis_tready = 1'b1;
        for (int l = 0; l < 4; l++) begin
            step(1, 0, '0);
            for (int n = 0; n < DL + AP; n++) begin
                step(0, 1, 12'($urandom));
                checks++;
                if (m_axis_tvalid !== (mq.size() != 0)) begin
                    errors++; $display("FAIL b2b_tvalid[%0d.%0d]: got %b expected %b", l, n, m_axis_tvalid, (mq.size() != 0));
                end
            end
        end
        step(0, 0, '0); step(0, 0, '0);
        checks++;
        if (obs_out.size() != 32) begin errors++; $display("FAIL b2b_count: got %0d expected 32", obs_out.size()); end
        nuser = 0;
        for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) begin
            checks++;
            if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, obs_out[i], exp_out[i]); end
            checks++;
            if (obs_out[i][9:8] !== {(i == 0 || i == 24), (i % 8 == 7)}) begin
                errors++; $display("FAIL b2b_flags[%0d]: got %b expected %b", i, obs_out[i][9:8], {(i == 0 || i == 24), (i % 8 == 7)});
            end
            if (obs_out[i][9]) nuser++;
        end
        checks++;
        if (nuser != 2) begin errors++; $display("FAIL b2b_tuser_count: got %0d expected 2", nuser); end
    endtask

    task automatic test_backpressure();
        logic [11:0] d;
        logic [9:0]  first;
        apply_reset();
        rows = 16'd3; m_axis_tready = 1'b0;
        first = '0;
        step(1, 0, '0);
        for (int n = 0; n < DL + AP; n++) begin
            d = 12'($urandom);
            if (n == DL) first = {1'b1, 1'b0, d[11:4]};
            step(0, 1, d);
            if (n >= DL) begin
                checks++;
                if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {1'b1, first}) begin
                    errors++; $display("FAIL bp_hold[%0d]: got %h expected %h", n,
                        {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, first});
                end
            end
            checks++;
            if (overflow !== (n >= DL + FD)) begin
                errors++; $display("FAIL bp_overflow[%0d]: got %b expected %b", n, overflow, (n >= DL + FD));
            end
        end
        m_axis_tready = 1'b1;
        for (int n = 0; n < 6; n++) step(0, 0, '0);
        checks++;
        if (obs_out.size() != FD) begin errors++; $display("FAIL bp_drain_count: got %0d expected %0d", obs_out.size(), FD); end
        for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) begin
            checks++;
            if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, obs_out[i], exp_out[i]); end
        end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_short_line();
        apply_reset();
        rows = 16'd3; m_axis_tready = 1'b1;
        step(1, 0, '0);
        for (int n = 0; n < DL + AP; n++) step(0, 1, 12'($urandom));
        step(1, 0, '0);
        for (int n = 0; n < DL + 5; n++) step(0, 1, 12'($urandom));
        checks++;
        if (short_line !== 1'b0) begin errors++; $display("FAIL short_before: got %b expected 0", short_line); end
        step(1, 0, '0);
        checks++;
        if (short_line !== 1'b1) begin errors++; $display("FAIL short_set: got %b expected 1", short_line); end
        for (int n = 0; n < DL + AP; n++) step(0, 1, 12'($urandom));
        step(0, 0, '0);
        checks++;
        if (obs_out.size() != 21) begin errors++; $display("FAIL short_count: got %0d expected 21", obs_out.size()); end
        for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) begin
            checks++;
            if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL short_word[%0d]: got %h expected %h", i, obs_out[i], exp_out[i]); end
        end
        if (obs_out.size() == 21) begin
            for (int i = 8; i < 13; i++) begin
                checks++;
                if (obs_out[i][9:8] !== 2'b00) begin errors++; $display("FAIL short_flags[%0d]: got %b expected 00", i, obs_out[i][9:8]); end
            end
            checks++;
            if (obs_out[13][9] !== 1'b1) begin errors++; $display("FAIL short_resync_tuser: got %b expected 1", obs_out[13][9]); end
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        rows = 16'd3; m_axis_tready = 1'b1;
        step(1, 0, '0);
        step(0, 1, 12'hAB0);
        step(0, 1, 12'hCD0);
        step(1, 1, 12'hFF0);
        for (int n = 0; n < DL + AP; n++) step(0, 1, 12'(n << 4));
        step(0, 0, '0);
        checks++;
        if (obs_out.size() != AP) begin errors++; $display("FAIL same_count: got %0d expected %0d", obs_out.size(), AP); end
        for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) begin
            checks++;
            if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL same_model[%0d]: got %h expected %h", i, obs_out[i], exp_out[i]); end
            checks++;
            if (obs_out[i] !== {(i == 0), (i == AP - 1), 8'(i + DL)}) begin
                errors++; $display("FAIL same_word[%0d]: got %h expected %h", i, obs_out[i], {(i == 0), (i == AP - 1), 8'(i + DL)});
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rows = 16'd3; m_axis_tready = 1'b0;
        step(1, 0, '0);
        for (int n = 0; n < DL + 1; n++) step(0, 1, 12'($urandom));
        step(1, 0, '0);
        for (int n = 0; n < DL + 2; n++) step(0, 1, 12'($urandom));
        checks++;
        if ({m_axis_tvalid, short_line} !== 2'b11) begin
            errors++; $display("FAIL mid_pre: got tvalid,short=%b expected 11", {m_axis_tvalid, short_line});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, overflow, short_line, m_axis_tdata} !== 11'd0) begin
            errors++; $display("FAIL mid_async: got %h expected 000", {m_axis_tvalid, overflow, short_line, m_axis_tdata});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        m_axis_tready = 1'b1;
        for (int n = 0; n < DL + AP; n++) begin
            step(0, 1, 12'($urandom));
            checks++;
            if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_no_output[%0d]: got %b expected 0", n, m_axis_tvalid); end
        end
        step(1, 0, '0);
        for (int n = 0; n < DL + AP; n++) step(0, 1, 12'($urandom));
        step(0, 0, '0);
        checks++;
        if (obs_out.size() != AP) begin errors++; $display("FAIL mid_recover_count: got %0d expected %0d", obs_out.size(), AP); end
        for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) begin
            checks++;
            if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL mid_word[%0d]: got %h expected %h", i, obs_out[i], exp_out[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_backpressure();
        test_short_line();
        test_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
